// File: rtl/mux_arbiter.sv
// Two-requester arbiter that owns a shared 3-bit 2:1 select path.
// Round-robin on contention, with a bounded hold before a forced hand-over.
module mux_arbiter #(
  parameter int unsigned MAX_HOLD = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0,
  input  logic       req1,
  input  logic [2:0] x0,
  input  logic [2:0] x1,
  output logic       gnt0,
  output logic       gnt1,
  output logic       sel,
  output logic [2:0] y,
  output logic       y_valid,
  output logic       busy
);

  localparam int unsigned HW = 4;
  localparam logic [HW-1:0] HOLD_MAX = HW'(MAX_HOLD - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic            last;
  logic [HW-1:0]   hold_cnt;
  logic            own_req;

  // Next owner: round-robin from IDLE, drop/forced hand-over while owned.
  always_comb begin
    state_nxt = state;
    own_req   = 1'b0;
    case (state)
      IDLE: begin
        if (req0 && req1)  state_nxt = last ? OWN0 : OWN1;
        else if (req0)     state_nxt = OWN0;
        else if (req1)     state_nxt = OWN1;
      end
      OWN0: begin
        own_req = req0;
        if (!req0)                            state_nxt = req1 ? OWN1 : IDLE;
        else if (req1 && hold_cnt == HOLD_MAX) state_nxt = OWN1;
      end
      OWN1: begin
        own_req = req1;
        if (!req1)                            state_nxt = req0 ? OWN0 : IDLE;
        else if (req0 && hold_cnt == HOLD_MAX) state_nxt = OWN0;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      last     <= 1'b1;
      hold_cnt <= '0;
      gnt0     <= 1'b0;
      gnt1     <= 1'b0;
      sel      <= 1'b0;
      y        <= 3'b000;
      y_valid  <= 1'b0;
      busy     <= 1'b0;
    end else begin
      state <= state_nxt;
      gnt0  <= (state_nxt == OWN0);
      gnt1  <= (state_nxt == OWN1);
      busy  <= (state_nxt != IDLE);
      // sel keeps its last owner while idle
      if (state_nxt == OWN0)      sel <= 1'b0;
      else if (state_nxt == OWN1) sel <= 1'b1;

      if (state_nxt != state) begin
        hold_cnt <= '0;
        if (state_nxt == OWN0)      last <= 1'b0;
        else if (state_nxt == OWN1) last <= 1'b1;
      end else if (own_req && hold_cnt != HOLD_MAX) begin
        hold_cnt <= hold_cnt + HW'(1);
      end

      y_valid <= own_req;
      if (own_req) y <= sel ? x1 : x0;
    end
  end

endmodule
